// File: rtl/xalu_ise_wb.sv
// -----------------------------------------------------------------------------
// xalu_ise_wb
//
// Writeback buffer that sits directly behind the xalu ISE datapath. Every
// custom instruction issued to the ISE (in_req) is captured together with its
// destination register index. An op the ISE did not claim (in_val=0) is
// captured as an "illegal" entry. Entries wait in a small in-order circular
// FIFO and are handed to the core writeback port under a valid/ready
// handshake. This decouples the single-cycle ISE from core writeback stalls.
//
// Parameters:
//   DEPTH  number of buffered entries (power of two, >= 2)
//   XLEN   result data width
//
// Ports:
//   ise_clk     in   clock, all state updates on the rising edge
//   ise_rst     in   asynchronous active-high reset
//   in_req      in   custom instruction issued this cycle
//   in_val      in   ISE claims the op and in_data is valid
//   in_rd       in   destination register index of the issued op
//   in_data     in   ISE result
//   in_ready    out  buffer can accept an entry this cycle
//   wb_val      out  head entry valid
//   wb_ready    in   core accepts the head entry
//   wb_rd       out  head entry destination index
//   wb_data     out  head entry result
//   wb_illegal  out  head entry was an unclaimed (illegal) encoding
//   wb_cnt      out  retired legal-op counter
//
// Optional feature (compile-time macro XALU_ISE_WB_CNT_EN):
//   defined   -> wb_cnt counts pops of legal entries, wrapping at 2^32
//   undefined -> no counter logic, wb_cnt is tied to zero
// -----------------------------------------------------------------------------
module xalu_ise_wb #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic            ise_clk,
  input  logic            ise_rst,
  input  logic            in_req,
  input  logic            in_val,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  output logic            in_ready,
  output logic            wb_val,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_illegal,
  output logic [31:0]     wb_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic push;
  logic pop;

  // in_ready depends only on registered occupancy, so a pop in the same cycle
  // never frees a slot for a push while full. This keeps wb_ready out of the
  // in_ready timing path.
  assign in_ready = (count_reg != CNT_W'(DEPTH));
  assign wb_val   = (count_reg != '0);

  assign push = in_req && in_ready;
  assign pop  = wb_val && wb_ready;

  // DEPTH is a power of two, so the natural modulo-2^PTR_W rollover of the
  // pointers is exactly the DEPTH-1 -> 0 wrap.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge ise_clk or posedge ise_rst) begin
    if (ise_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry formatting
  // ---------------------------------------------------------------------------
  // Unclaimed ops carry no result, and a write to x0 must never deliver a
  // non-zero value, so both cases store zero data.
  logic            new_illegal;
  logic [XLEN-1:0] new_data;

  assign new_illegal = !in_val;
  assign new_data    = (in_val && (in_rd != 5'd0)) ? in_data : '0;

  // ---------------------------------------------------------------------------
  // Storage: one register set per slot. Every slot is cleared on reset, which
  // also guarantees the head (slot 0 after reset) reads as all zeros.
  // ---------------------------------------------------------------------------
  logic            ill_arr  [DEPTH];
  logic [4:0]      rd_arr   [DEPTH];
  logic [XLEN-1:0] data_arr [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic            ill_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] data_reg;
    logic            wr_en;

    assign wr_en = push && (wr_ptr_reg == PTR_W'(gi));

    always_ff @(posedge ise_clk or posedge ise_rst) begin
      if (ise_rst) begin
        ill_reg  <= 1'b0;
        rd_reg   <= '0;
        data_reg <= '0;
      end else if (wr_en) begin
        ill_reg  <= new_illegal;
        rd_reg   <= in_rd;
        data_reg <= new_data;
      end
    end

    assign ill_arr[gi]  = ill_reg;
    assign rd_arr[gi]   = rd_reg;
    assign data_arr[gi] = data_reg;
  end

  // Head entry comes straight from registered storage; a freshly pushed entry
  // therefore appears one cycle after its push, with no bypass. The slot under
  // rd_ptr is never written while it holds the head, so outputs stay stable
  // while the core stalls.
  assign wb_illegal = ill_arr[rd_ptr_reg];
  assign wb_rd      = rd_arr[rd_ptr_reg];
  assign wb_data    = data_arr[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Retired legal-op counter
  // ---------------------------------------------------------------------------
`ifdef XALU_ISE_WB_CNT_EN
  logic [31:0] cnt_reg;

  // Wraps naturally from 0xFFFFFFFF to 0.
  always_ff @(posedge ise_clk or posedge ise_rst) begin
    if (ise_rst) begin
      cnt_reg <= '0;
    end else if (pop && !wb_illegal) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign wb_cnt = cnt_reg;
`else
  assign wb_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_xalu_ise_wb.sv
// -----------------------------------------------------------------------------
// Self-checking bench for xalu_ise_wb. A queue of expected entries models the
// buffer: pushes append, pops remove the front, capacity is DEPTH and
// acceptance is decided from the occupancy at the start of the cycle.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_xalu_ise_wb;

  localparam int DEPTH = 2;
  localparam int XLEN  = 64;

  logic            ise_clk;
  logic            ise_rst;
  logic            in_req;
  logic            in_val;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;
  logic            in_ready;
  logic            wb_val;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_illegal;
  logic [31:0]     wb_cnt;

  xalu_ise_wb #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .ise_clk    (ise_clk),
    .ise_rst    (ise_rst),
    .in_req     (in_req),
    .in_val     (in_val),
    .in_rd      (in_rd),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wb_val     (wb_val),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_illegal (wb_illegal),
    .wb_cnt     (wb_cnt)
  );

  initial ise_clk = 1'b0;
  always #5 ise_clk = ~ise_clk;

  typedef struct packed {
    logic            ill;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            exp_q[$];
  logic [XLEN-1:0] dut_ret_q[$];
  int              legal_retired;
  bit              accepted;
  int              n_vec;
  int              n_err;

  function automatic logic [31:0] exp_cnt();
`ifdef XALU_ISE_WB_CNT_EN
    return 32'(legal_retired);
`else
    return 32'd0;
`endif
  endfunction

  // Drive one cycle of stimulus and advance the reference queue.
  task automatic cycle(input logic req, input logic val, input logic [4:0] rd,
                       input logic [XLEN-1:0] data, input logic rdy);
    ent_t e;
    bit   do_push;
    bit   do_pop;
    in_req   = req;
    in_val   = val;
    in_rd    = rd;
    in_data  = data;
    wb_ready = rdy;
    do_push  = req && (exp_q.size() < DEPTH);
    do_pop   = (exp_q.size() != 0) && rdy;
    #1;
    if (wb_val && wb_ready) dut_ret_q.push_back(wb_data);
    @(posedge ise_clk);
    if (do_pop) begin
      e = exp_q.pop_front();
      if (!e.ill) legal_retired++;
    end
    if (do_push) begin
      e.ill  = !val;
      e.rd   = rd;
      e.data = (val && rd != 5'd0) ? data : '0;
      exp_q.push_back(e);
    end
    accepted = do_push;
    @(negedge ise_clk);
  endtask

  task automatic apply_reset();
    ise_rst  = 1'b1;
    in_req   = 1'b0;
    in_val   = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    wb_ready = 1'b0;
    @(posedge ise_clk);
    @(negedge ise_clk);
    ise_rst = 1'b0;
    exp_q.delete();
    dut_ret_q.delete();
    legal_retired = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (wb_val !== 1'b0) begin n_err++; $display("FAIL reset_wb_val got=%b exp=0", wb_val); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_vec++;
    if (wb_rd !== 5'd0 || wb_data !== '0 || wb_illegal !== 1'b0) begin
      n_err++; $display("FAIL reset_head got rd=%0d data=%h ill=%b exp 0/0/0", wb_rd, wb_data, wb_illegal);
    end
    n_vec++;
    if (wb_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", wb_cnt); end
  endtask

  task automatic test_single();
    cycle(1'b1, 1'b1, 5'd5, 64'h0123456789ABCDEF, 1'b1);
    n_vec++;
    if (wb_val !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'h0123456789ABCDEF || wb_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL single_head got val=%b rd=%0d data=%h ill=%b exp 1/5/0123456789abcdef/0",
               wb_val, wb_rd, wb_data, wb_illegal);
    end
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
    n_vec++;
    if (wb_val !== 1'b0) begin n_err++; $display("FAIL single_drain got val=%b exp=0", wb_val); end
  endtask

  task automatic test_full();
    cycle(1'b1, 1'b1, 5'd1, 64'h11, 1'b0);
    cycle(1'b1, 1'b1, 5'd2, 64'h22, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || wb_val !== 1'b1 || wb_data !== 64'h11) begin
      n_err++; $display("FAIL full_hold got rdy=%b val=%b data=%h exp 0/1/11", in_ready, wb_val, wb_data);
    end
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b0);
    n_vec++;
    if (wb_data !== 64'h11 || wb_rd !== 5'd1) begin
      n_err++; $display("FAIL full_stable got data=%h rd=%0d exp 11/1", wb_data, wb_rd);
    end
    // Pop and push together while full: the push must be refused.
    cycle(1'b1, 1'b1, 5'd3, 64'h33, 1'b1);
    n_vec++;
    if (wb_val !== 1'b1 || wb_data !== 64'h22 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL full_popsecond got val=%b data=%h rdy=%b exp 1/22/1", wb_val, wb_data, in_ready);
    end
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
    n_vec++;
    if (wb_val !== 1'b0) begin n_err++; $display("FAIL full_no_third got val=%b exp=0", wb_val); end
  endtask

  task automatic test_illegal();
    cycle(1'b1, 1'b0, 5'd7, 64'hDEAD, 1'b0);
    n_vec++;
    if (wb_illegal !== 1'b1 || wb_rd !== 5'd7 || wb_data !== '0) begin
      n_err++; $display("FAIL illegal_head got ill=%b rd=%0d data=%h exp 1/7/0", wb_illegal, wb_rd, wb_data);
    end
    cycle(1'b1, 1'b1, 5'd9, 64'h1234, 1'b1);
    n_vec++;
    if (wb_illegal !== 1'b0 || wb_rd !== 5'd9 || wb_data !== 64'h1234) begin
      n_err++; $display("FAIL illegal_next got ill=%b rd=%0d data=%h exp 0/9/1234", wb_illegal, wb_rd, wb_data);
    end
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
  endtask

  task automatic test_rd_zero();
    cycle(1'b1, 1'b1, 5'd0, 64'hFFFF, 1'b0);
    n_vec++;
    if (wb_val !== 1'b1 || wb_data !== '0 || wb_illegal !== 1'b0) begin
      n_err++; $display("FAIL rd_zero got val=%b data=%h ill=%b exp 1/0/0", wb_val, wb_data, wb_illegal);
    end
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
    // in_val without in_req must not push anything.
    cycle(1'b0, 1'b1, 5'd3, 64'h55, 1'b1);
    n_vec++;
    if (wb_val !== 1'b0) begin n_err++; $display("FAIL val_no_req got val=%b exp=0", wb_val); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
      n_vec++;
      if (wb_val !== (exp_q.size() != 0) || in_ready !== (exp_q.size() != DEPTH)) begin
        n_err++; $display("FAIL rand_flags cyc=%0d got val=%b rdy=%b exp occupancy=%0d", i, wb_val, in_ready, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        n_vec++;
        if (wb_illegal !== exp_q[0].ill || wb_rd !== exp_q[0].rd || wb_data !== exp_q[0].data) begin
          n_err++;
          $display("FAIL rand_head cyc=%0d got ill=%b rd=%0d data=%h exp ill=%b rd=%0d data=%h",
                   i, wb_illegal, wb_rd, wb_data, exp_q[0].ill, exp_q[0].rd, exp_q[0].data);
        end
      end
      n_vec++;
      if (wb_cnt !== exp_cnt()) begin
        n_err++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, wb_cnt, exp_cnt());
      end
    end
  endtask

  task automatic test_wrap();
    int pushed;
    int cyc;
    apply_reset();
    pushed = 0;
    cyc    = 0;
    while ((pushed < 9 || exp_q.size() != 0) && cyc < 100) begin
      cycle(pushed < 9, 1'b1, 5'd1 + 5'(pushed), 64'h100 + 64'(pushed), 1'(cyc % 2));
      if (accepted) pushed++;
      cyc++;
    end
    n_vec++;
    if (dut_ret_q.size() != 9) begin
      n_err++; $display("FAIL wrap_count got=%0d exp=9", dut_ret_q.size());
    end
    for (int i = 0; i < 9 && i < dut_ret_q.size(); i++) begin
      n_vec++;
      if (dut_ret_q[i] !== 64'h100 + 64'(i)) begin
        n_err++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, dut_ret_q[i], 64'h100 + 64'(i));
      end
    end
    n_vec++;
`ifdef XALU_ISE_WB_CNT_EN
    if (wb_cnt !== 32'd9) begin n_err++; $display("FAIL wrap_cnt got=%0d exp=9", wb_cnt); end
`else
    if (wb_cnt !== 32'd0) begin n_err++; $display("FAIL wrap_cnt got=%0d exp=0", wb_cnt); end
`endif
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b1, 5'd4, 64'h44, 1'b0);
    cycle(1'b1, 1'b1, 5'd6, 64'h66, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL arst_prefull got rdy=%b exp=0", in_ready); end
    in_req = 1'b0;
    #2;
    ise_rst = 1'b1;
    #1;
    n_vec++;
    if (wb_val !== 1'b0 || in_ready !== 1'b1 || wb_data !== '0 || wb_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL arst_immediate got val=%b rdy=%b data=%h cnt=%0d exp 0/1/0/0", wb_val, in_ready, wb_data, wb_cnt);
    end
    @(negedge ise_clk);
    ise_rst = 1'b0;
    exp_q.delete();
    legal_retired = 0;
    cycle(1'b1, 1'b1, 5'd8, 64'hAA, 1'b0);
    n_vec++;
    if (wb_val !== 1'b1 || wb_data !== 64'hAA || wb_rd !== 5'd8) begin
      n_err++; $display("FAIL arst_after got val=%b data=%h rd=%0d exp 1/aa/8", wb_val, wb_data, wb_rd);
    end
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
    n_vec++;
    if (wb_val !== 1'b0) begin n_err++; $display("FAIL arst_no_stale got val=%b exp=0", wb_val); end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    legal_retired = 0;
    accepted      = 1'b0;
    ise_rst       = 1'b1;
    in_req        = 1'b0;
    in_val        = 1'b0;
    in_rd         = '0;
    in_data       = '0;
    wb_ready      = 1'b0;
    @(negedge ise_clk);
    test_reset();
    test_single();
    test_full();
    test_illegal();
    test_rd_zero();
    test_random();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
